// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_ADDR_W-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush and a registered head.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             head_valid_o,
  output fetch_entry_t     head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  fetch_entry_t     head_q, head_d;
  logic             do_push, do_pop;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Head register looks ahead: a word written this cycle may be the next head.
    head_valid_d = (count_d != '0);
    head_d       = head_q;
    if (count_d != '0) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_entry_i : mem_q[rd_ptr_d];
    end
  end

  // NOTE: state flops use non-blocking assignments and the async active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  // NOTE: storage is left unreset; occupancy is tracked by count_q, so stale words are never read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_next_o = count_d;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front end: sequential PC, single outstanding fetch, redirect flush.
// Optional PREFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_prefetch_queue #(
  parameter int unsigned       DATA_W   = cpu_fetch_pkg::FETCH_DATA_W,
  parameter int unsigned       ADDR_W   = cpu_fetch_pkg::FETCH_ADDR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_fetch_pkg::RESET_PC,
  parameter logic [ADDR_W-1:0] PC_STEP  = cpu_fetch_pkg::PC_STEP
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0] out_pc_o,
  input  logic              out_ready_i
);

  import cpu_fetch_pkg::*;

  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_q, req_d;

  logic              push, pop, resp_ok, bypass_hit;
  fetch_entry_t      push_entry, head;
  logic              head_valid;
  logic [CNT_W-1:0]  count_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end else if (imem_req_o && imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid_i) begin
          pc_d    = redirect_pc_i;
          state_d = imem_rvalid_i ? FETCH : DISCARD;
        end else if (imem_rvalid_i) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_valid_i) pc_d = redirect_pc_i;
        if (imem_rvalid_i)    state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Request only when a slot is reserved for its response.
    req_d = (state_d == FETCH) && (count_next < DEPTH_C);
  end

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = (state_q == WAIT) && imem_rvalid_i && !redirect_valid_i && !head_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    imem_req_o       = req_q && !redirect_valid_i;
    imem_addr_o      = pc_q;
    resp_ok          = (state_q == WAIT) && imem_rvalid_i && !redirect_valid_i;
    push             = resp_ok && !(bypass_hit && out_ready_i);
    pop              = out_ready_i && head_valid && !redirect_valid_i;
    push_entry.pc    = req_pc_q;
    push_entry.instr = imem_rdata_i;
    out_valid_o      = head_valid || bypass_hit;
    out_pc_o         = bypass_hit ? req_pc_q : head.pc;
    out_instr_o      = bypass_hit ? imem_rdata_i : head.instr;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid_i),
    .count_next_o (count_next),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a single-outstanding memory model.
module tb_instr_prefetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  instr_prefetch_queue dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_valid_o      (out_valid),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .out_ready_i      (out_ready)
  );

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic        s_req, s_val;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [31:0] gnt_log[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_instr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_at(input string name, input logic [31:0] q[$], input int idx,
                          input logic [31:0] exp);
    if (idx < q.size()) begin
      check(name, q[idx], exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: entry %0d missing, expected %h", name, idx, exp);
    end
  endtask

  // Sample at negedge, then drive the next cycle's memory response just after posedge.
  task automatic cycle();
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_val = out_valid; s_pc = out_pc; s_instr = out_instr;
    if (s_req && imem_gnt) begin
      gnt_log.push_back(s_addr);
      mem_busy = 1'b1; mem_cnt = lat; mem_addr = s_addr;
    end
    if (s_val && out_ready && !redirect_valid) begin
      obs_pc.push_back(s_pc);
      obs_instr.push_back(s_instr);
    end
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ K;
        mem_busy    = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; mem_busy = 1'b0;
    gnt_log.delete(); obs_pc.delete(); obs_instr.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        val;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[8];
  logic fired;

  initial begin
    // Cycle-by-cycle view after reset release, 1-cycle memory, decode always ready.
    tv[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
`ifdef PREFETCH_BYPASS_EN
    tv[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
    tv[3] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
    tv[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4};
    tv[5] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0};
    tv[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};
    tv[7] = '{1'b1, 1'b1, 32'hC, 1'b0, 32'h0};
`else
    tv[2] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    tv[4] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[5] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tv[6] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[7] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};
`endif

    // Test 1: sequential fetch
    lat = 1; do_reset();
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_out_instr", out_instr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      out_ready = tv[i].rdy;
      cycle();
      check($sformatf("t1_req_c%0d", i), {31'b0, s_req}, {31'b0, tv[i].req});
      if (tv[i].req) check($sformatf("t1_addr_c%0d", i), s_addr, tv[i].addr);
      check($sformatf("t1_val_c%0d", i), {31'b0, s_val}, {31'b0, tv[i].val});
      if (tv[i].val) begin
        check($sformatf("t1_pc_c%0d", i), s_pc, tv[i].pc);
        check($sformatf("t1_instr_c%0d", i), s_instr, tv[i].pc ^ K);
      end
    end

    // Test 2: backpressure fills exactly DEPTH entries, then drains in order
    lat = 1; out_ready = 1'b0; do_reset();
    repeat (20) cycle();
    check("t2_grants", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_at($sformatf("t2_gnt%0d", i), gnt_log, i, 32'(i * 4));
    check("t2_req_stalled", {31'b0, s_req}, 32'd0);
    check("t2_head_pc", s_pc, 32'h0);
    out_ready = 1'b1;
    repeat (12) cycle();
    for (int i = 0; i < 4; i++) begin
      check_at($sformatf("t2_obs_pc%0d", i), obs_pc, i, 32'(i * 4));
      check_at($sformatf("t2_obs_instr%0d", i), obs_instr, i, 32'(i * 4) ^ K);
    end
    check_at("t2_resume", gnt_log, 4, 32'h10);

    // Test 3: redirect while waiting on a slow response
    lat = 3; out_ready = 1'b1; do_reset(); fired = 1'b0;
    for (int i = 0; i < 60 && !fired; i++) begin
      cycle();
      if (gnt_log.size() == 3) begin
        redirect_valid = 1'b1; redirect_pc = 32'h100; fired = 1'b1;
      end
    end
    check("t3_fired", {31'b0, fired}, 32'd1);
    cycle(); cycle();
    check("t3_flushed", {31'b0, s_val}, 32'd0);
    repeat (20) cycle();
    check_at("t3_gnt_redirect", gnt_log, 3, 32'h100);
    check_at("t3_obs_pc", obs_pc, 2, 32'h100);
    check_at("t3_obs_instr", obs_instr, 2, 32'h100 ^ K);

    // Test 4: redirect coincides with rvalid and with a decode pop
    lat = 1; out_ready = 1'b0; do_reset(); fired = 1'b0;
    for (int i = 0; i < 60 && !fired; i++) begin
      cycle();
      if (imem_rvalid && gnt_log.size() == 3) begin
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; fired = 1'b1;
      end
    end
    check("t4_fired", {31'b0, fired}, 32'd1);
    cycle(); cycle();
    check("t4_flushed", {31'b0, s_val}, 32'd0);
    check("t4_req", {31'b0, s_req}, 32'd1);
    check("t4_addr", s_addr, 32'h200);
    repeat (8) cycle();
    check_at("t4_obs_pc", obs_pc, 0, 32'h200);
    check_at("t4_obs_instr", obs_instr, 0, 32'h200 ^ K);

    // Test 5: reset mid-WAIT, stale response after release
    lat = 1; out_ready = 1'b1; do_reset(); fired = 1'b0;
    for (int i = 0; i < 60 && !fired; i++) begin
      cycle();
      if (gnt_log.size() == 3) fired = 1'b1;
    end
    check("t5_fired", {31'b0, fired}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("t5_rst_req", {31'b0, imem_req}, 32'd0);
    check("t5_rst_val", {31'b0, out_valid}, 32'd0);
    check("t5_rst_pc", out_pc, 32'h0);
    check("t5_rst_instr", out_instr, 32'h0);
    mem_busy = 1'b0; gnt_log.delete(); obs_pc.delete(); obs_instr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (8) cycle();
    check_at("t5_restart", gnt_log, 0, 32'h0);
    check_at("t5_obs_pc", obs_pc, 0, 32'h0);
    check_at("t5_obs_instr", obs_instr, 0, K);

    // Test 6: response-to-output latency with an empty queue
    lat = 1; out_ready = 1'b1; do_reset();
    cycle(); cycle(); cycle();
    check("t6_rvalid", {31'b0, imem_rvalid}, 32'd0);
`ifdef PREFETCH_BYPASS_EN
    check("t6_same_cycle_val", {31'b0, s_val}, 32'd1);
    check("t6_same_cycle_pc", s_pc, 32'h0);
    cycle();
    check("t6_not_queued", {31'b0, s_val}, 32'd0);
`else
    check("t6_same_cycle_val", {31'b0, s_val}, 32'd0);
    cycle();
    check("t6_next_cycle_val", {31'b0, s_val}, 32'd1);
    check("t6_next_cycle_pc", s_pc, 32'h0);
`endif

    // Test 7: redirect in FETCH suppresses the request; PC wraps past the top
    lat = 1; out_ready = 1'b1; do_reset();
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    check("t7_suppressed", {31'b0, s_req}, 32'd0);
    check("t7_no_grant", gnt_log.size(), 32'd0);
    repeat (6) cycle();
    check_at("t7_gnt_top", gnt_log, 0, 32'hFFFF_FFFC);
    check_at("t7_gnt_wrap", gnt_log, 1, 32'h0);
    check_at("t7_obs_pc", obs_pc, 0, 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
